// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU response scoreboard:
//                opcode encodings, flag bit indices, mismatch-record
//                field offsets and the scoreboard state type.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

   // Opcode map; everything above OP_LAST is illegal
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_LAST = 4'd5;

   // Flag vector layout {carry, zero, negative, overflow}
   localparam int NUM_FLAGS = 4;
   localparam int FLAG_C    = 3;
   localparam int FLAG_Z    = 2;
   localparam int FLAG_N    = 1;
   localparam int FLAG_V    = 0;

   // Mismatch record {opcode, exp_result, dut_result, exp_flags, dut_flags}
   localparam int ERR_DUT_FLAGS_LSB = 0;
   localparam int ERR_EXP_FLAGS_LSB = NUM_FLAGS;
   localparam int ERR_DUT_RES_LSB   = 2 * NUM_FLAGS;

   function automatic int err_exp_res_lsb(input int width);
      return 2 * NUM_FLAGS + width;
   endfunction

   function automatic int err_op_lsb(input int width);
      return 2 * NUM_FLAGS + 2 * width;
   endfunction

   function automatic int err_rec_w(input int width);
      return 4 + 2 * width + 2 * NUM_FLAGS;
   endfunction

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } sb_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_ref_model.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ref_model
//  Description : Combinational golden model of the ALU. Produces the result
//                and {carry, zero, negative, overflow} flags expected for a
//                given operand pair and opcode, and flags illegal opcodes.
//  Revision    : 1.0  initial release
//  Ports       : a, b        operands (WIDTH)
//                opcode      4-bit opcode
//                exp_result  expected result (WIDTH)
//                exp_flags   expected flags {C,Z,N,V}
//                illegal     opcode outside the legal map
// ============================================================================
module alu_ref_model
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [3:0]           opcode,
   output logic [WIDTH-1:0]     exp_result,
   output logic [NUM_FLAGS-1:0] exp_flags,
   output logic                 illegal
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;
   logic           w_carry;
   logic           w_ovf;

   always_comb begin
      // Extra top bit holds the carry-out / borrow
      w_sum      = {1'b0, a} + {1'b0, b};
      w_diff     = {1'b0, a} - {1'b0, b};
      exp_result = '0;
      w_carry    = 1'b0;
      w_ovf      = 1'b0;
      illegal    = 1'b0;
      case (opcode)
         OP_ADD: begin
            exp_result = w_sum[WIDTH-1:0];
            w_carry    = w_sum[WIDTH];
            w_ovf      = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            exp_result = w_diff[WIDTH-1:0];
            w_carry    = w_diff[WIDTH];   // borrow, i.e. a < b unsigned
            w_ovf      = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  exp_result = a & b;
         OP_OR:   exp_result = a | b;
         OP_XOR:  exp_result = a ^ b;
         OP_SLT:  exp_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: illegal = 1'b1;
      endcase
      exp_flags         = '0;
      exp_flags[FLAG_C] = w_carry;
      exp_flags[FLAG_Z] = (exp_result == '0);
      exp_flags[FLAG_N] = exp_result[WIDTH-1];
      exp_flags[FLAG_V] = w_ovf;
   end

endmodule
`default_nettype wire

// File: rtl/alu_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : alu_scoreboard
//  Description : Response checker for the ALU interface. Captures one
//                transaction per handshake, recomputes the expected result
//                with alu_ref_model one cycle later, counts pass / fail /
//                skip (illegal opcode) and queues mismatch records in a FIFO.
//                Halts after MAX_ERR fails (0 = never) until clear.
//  Revision    : 1.0  initial release
//  Macro       : ALU_SB_FLAGS_EN - when defined, flags must match as well as
//                the result; otherwise only the result is compared.
//  Ports       : clk, rst_n                 clock, async active-low reset
//                in_valid/in_ready          transaction handshake
//                A, B, opcode               ALU stimulus
//                result, carry, zero,
//                negative, overflow         ALU response
//                clear                      sync clear of counters/FIFO/HALT
//                pass/fail/skip_count       saturating counters (CNT_W)
//                halted                     HALT state indicator
//                err_valid/err_ready        mismatch FIFO pop handshake
//                err_data                   head mismatch record
// ============================================================================
module alu_scoreboard
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_ERR    = 8,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              A,
   input  logic [WIDTH-1:0]              B,
   input  logic [3:0]                    opcode,
   input  logic [WIDTH-1:0]              result,
   input  logic                          carry,
   input  logic                          zero,
   input  logic                          negative,
   input  logic                          overflow,
   input  logic                          clear,
   output logic [CNT_W-1:0]              pass_count,
   output logic [CNT_W-1:0]              fail_count,
   output logic [CNT_W-1:0]              skip_count,
   output logic                          halted,
   output logic                          err_valid,
   input  logic                          err_ready,
   output logic [err_rec_w(WIDTH)-1:0]   err_data
);

   localparam int c_rec_w = err_rec_w(WIDTH);
   localparam int c_aw    = $clog2(FIFO_DEPTH);
   localparam int c_cw    = c_aw + 1;

   sb_state_t r_state, w_state_nxt;
   logic      r_live;   // low until the first edge after reset release

   // Stage 1 capture
   logic                 r_s1_valid;
   logic [WIDTH-1:0]     r_s1_a, r_s1_b, r_s1_res;
   logic [3:0]           r_s1_op;
   logic [NUM_FLAGS-1:0] r_s1_flags;
   logic [NUM_FLAGS-1:0] w_in_flags;

   // Golden model outputs
   logic [WIDTH-1:0]     w_exp_res;
   logic [NUM_FLAGS-1:0] w_exp_flags;
   logic                 w_illegal;

   logic w_take, w_fire, w_match, w_pass, w_fail, w_skip, w_pop, w_hit_max;
   logic [CNT_W:0] w_fail_inc;

   // Mismatch FIFO
   logic [c_rec_w-1:0] r_mem [FIFO_DEPTH];
   logic [c_aw-1:0]    r_wr_ptr, r_rd_ptr;
   logic [c_cw-1:0]    r_count;
   logic [c_cw-1:0]    w_occupancy;
   logic [c_rec_w-1:0] w_rec;

   alu_ref_model #(.WIDTH(WIDTH)) u_ref (
      .a          (r_s1_a),
      .b          (r_s1_b),
      .opcode     (r_s1_op),
      .exp_result (w_exp_res),
      .exp_flags  (w_exp_flags),
      .illegal    (w_illegal)
   );

   always_comb begin
      w_in_flags         = '0;
      w_in_flags[FLAG_C] = carry;
      w_in_flags[FLAG_Z] = zero;
      w_in_flags[FLAG_N] = negative;
      w_in_flags[FLAG_V] = overflow;
   end

   // Counting the stage-1 entry as occupied reserves a FIFO slot for it,
   // so a mismatch can never find the FIFO full.
   assign w_occupancy = r_count + c_cw'(r_s1_valid);
   assign in_ready    = r_live && (r_state == ST_RUN) && (w_occupancy < c_cw'(FIFO_DEPTH));
   assign w_take      = in_valid && in_ready && !clear;
   assign w_fire      = r_s1_valid && !clear;

`ifdef ALU_SB_FLAGS_EN
   assign w_match = (r_s1_res == w_exp_res) && (r_s1_flags == w_exp_flags);
`else
   assign w_match = (r_s1_res == w_exp_res);
`endif

   assign w_skip = w_fire && w_illegal;
   assign w_pass = w_fire && !w_illegal && w_match;
   assign w_fail = w_fire && !w_illegal && !w_match;

   assign err_valid = (r_count != '0);
   assign err_data  = err_valid ? r_mem[r_rd_ptr] : '0;
   assign w_pop     = err_valid && err_ready && !clear;
   assign halted    = (r_state == ST_HALT);

   // The fail that brings the count up to MAX_ERR triggers the halt
   assign w_fail_inc = {1'b0, fail_count} + {{CNT_W{1'b0}}, 1'b1};
   assign w_hit_max  = (MAX_ERR != 0) && (w_fail_inc == (CNT_W+1)'(MAX_ERR));

   always_comb begin
      w_rec = '0;
      w_rec[ERR_DUT_FLAGS_LSB +: NUM_FLAGS]  = r_s1_flags;
      w_rec[ERR_EXP_FLAGS_LSB +: NUM_FLAGS]  = w_exp_flags;
      w_rec[ERR_DUT_RES_LSB +: WIDTH]        = r_s1_res;
      w_rec[err_exp_res_lsb(WIDTH) +: WIDTH] = w_exp_res;
      w_rec[err_op_lsb(WIDTH) +: 4]          = r_s1_op;
   end

   // FSM
   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = ST_RUN;
      end else if ((r_state == ST_RUN) && w_fail && w_hit_max) begin
         w_state_nxt = ST_HALT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
      end
   end

   // Stage 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_res   <= '0;
         r_s1_op    <= '0;
         r_s1_flags <= '0;
      end else begin
         r_s1_valid <= w_take;
         if (w_take) begin
            r_s1_a     <= A;
            r_s1_b     <= B;
            r_s1_res   <= result;
            r_s1_op    <= opcode;
            r_s1_flags <= w_in_flags;
         end
      end
   end

   // Saturating counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_count <= '0;
         fail_count <= '0;
         skip_count <= '0;
      end else if (clear) begin
         pass_count <= '0;
         fail_count <= '0;
         skip_count <= '0;
      end else begin
         if (w_pass && (pass_count != '1)) pass_count <= pass_count + 1'b1;
         if (w_fail && (fail_count != '1)) fail_count <= fail_count + 1'b1;
         if (w_skip && (skip_count != '1)) skip_count <= skip_count + 1'b1;
      end
   end

   // FIFO control; pointers wrap naturally as FIFO_DEPTH is a power of 2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_fail) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_fail && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_fail && w_pop) r_count <= r_count - 1'b1;
      end
   end

   // Storage needs no reset: err_data is masked while the FIFO is empty
   always_ff @(posedge clk) begin
      if (w_fail) r_mem[r_wr_ptr] <= w_rec;
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_scoreboard
//  Description : Directed self-checking bench for alu_scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_scoreboard;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] A = '0, B = '0, result = '0;
   logic [3:0]  opcode = '0;
   logic        carry = 1'b0, zero = 1'b0, negative = 1'b0, overflow = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] pass_count, fail_count, skip_count;
   logic        halted, err_valid;
   logic        err_ready = 1'b0;
   logic [75:0] err_data;

   int tests = 0, fails = 0;
   int e_pass = 0, e_fail = 0, e_skip = 0;

   always #5 clk = ~clk;

   alu_scoreboard #(.WIDTH(32), .FIFO_DEPTH(4), .MAX_ERR(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .opcode(opcode), .result(result),
      .carry(carry), .zero(zero), .negative(negative), .overflow(overflow),
      .clear(clear), .pass_count(pass_count), .fail_count(fail_count),
      .skip_count(skip_count), .halted(halted), .err_valid(err_valid),
      .err_ready(err_ready), .err_data(err_data)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_pass"}, pass_count, e_pass);
      chk({tag, "_fail"}, fail_count, e_fail);
      chk({tag, "_skip"}, skip_count, e_skip);
   endtask

   // Called at a negedge; returns at the negedge after the transfer edge
   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] fl);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", in_ready, 1'b1);
      opcode = op; A = a; B = b; result = res;
      {carry, zero, negative, overflow} = fl;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pop();
      err_ready = 1'b1;
      @(negedge clk);
      err_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk_cnt("rst");
      chk("rst_halted", halted, 1'b0);
      chk("rst_err_valid", err_valid, 1'b0);
      chk("rst_err_data", err_data, 76'h0);
      rst_n = 1'b1;
      #1 chk("ready_before_edge", in_ready, 1'b0);
      @(negedge clk);
      chk("ready_after_edge", in_ready, 1'b1);

      // ADD 200+100
      send(OP_ADD, 32'd200, 32'd100, 32'd300, 4'b0000);
      @(negedge clk);
      e_pass = 1;
      chk_cnt("add_basic");
      chk("add_basic_errv", err_valid, 1'b0);

      // ADD with carry-out and zero
      send(OP_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b1100);
      @(negedge clk);
      e_pass = 2;
      chk_cnt("add_carry");

      // Same ADD, wrong carry flag
      send(OP_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0100);
      @(negedge clk);
`ifdef ALU_SB_FLAGS_EN
      e_fail = 1;
      chk_cnt("add_badflag");
      chk("add_badflag_errv", err_valid, 1'b1);
      chk("add_badflag_rec", err_data, {4'd0, 32'h0, 32'h0, 4'b1100, 4'b0100});
      pop();
      chk("add_badflag_pop", err_valid, 1'b0);
`else
      e_pass = 3;
      chk_cnt("add_badflag");
      chk("add_badflag_errv", err_valid, 1'b0);
`endif

      // SUB 5-7 with borrow
      send(OP_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 4'b1010);
      @(negedge clk);
      e_pass++;
      chk_cnt("sub_ok");

      // Same SUB, wrong result
      send(OP_SUB, 32'd5, 32'd7, 32'hFFFFFFFD, 4'b1010);
      @(negedge clk);
      e_fail++;
      chk_cnt("sub_bad");
      chk("sub_bad_errv", err_valid, 1'b1);
      chk("sub_bad_rec", err_data, {4'd1, 32'hFFFFFFFE, 32'hFFFFFFFD, 4'b1010, 4'b1010});
      pop();
      chk("sub_bad_pop", err_valid, 1'b0);

      // Illegal opcode
      send(4'd9, 32'd1, 32'd2, 32'd3, 4'b0000);
      @(negedge clk);
      e_skip = 1;
      chk_cnt("illegal");
      chk("illegal_errv", err_valid, 1'b0);

      // Logic ops and signed SLT
      send(OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b0000);
      send(OP_SLT, 32'd1, 32'hFFFFFFFF, 32'd0, 4'b0100);
      send(OP_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 4'b0000);
      send(OP_XOR, 32'h5, 32'h5, 32'h0, 4'b0100);
      @(negedge clk);
      e_pass += 4;
      chk_cnt("logic_slt");
      chk("logic_slt_errv", err_valid, 1'b0);

      // Four back-to-back mismatches fill the FIFO
      send(OP_ADD, 32'h7FFFFFFF, 32'd1, 32'd0, 4'b0000);
      send(OP_SUB, 32'h80000000, 32'd1, 32'd0, 4'b0000);
      send(OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0000);
      send(OP_OR,  32'd0, 32'd0, 32'd5, 4'b0000);
      chk("full_ready_low", in_ready, 1'b0);
      @(negedge clk);
      e_fail += 4;
      chk_cnt("full");
      chk("full_ready_low2", in_ready, 1'b0);
      chk("full_rec1", err_data, {4'd0, 32'h80000000, 32'h0, 4'b0011, 4'b0000});
      pop();
      chk("pop1_ready", in_ready, 1'b1);
      chk("full_rec2", err_data, {4'd1, 32'h7FFFFFFF, 32'h0, 4'b0001, 4'b0000});
      pop();
      chk("full_rec3", err_data, {4'd5, 32'h1, 32'h0, 4'b0000, 4'b0000});
      pop();
      chk("full_rec4", err_data, {4'd3, 32'h0, 32'h5, 4'b0100, 4'b0000});
      pop();
      chk("full_drained", err_valid, 1'b0);

      // Mismatches up to MAX_ERR halt the block
      for (int k = e_fail; k < 8; k++) send(OP_ADD, 32'd1, 32'd1, 32'd0, 4'b0000);
      @(negedge clk);
      e_fail = 8;
      chk_cnt("halt");
      chk("halt_halted", halted, 1'b1);
      chk("halt_ready", in_ready, 1'b0);

      // Offered transaction in HALT is not accepted; FIFO still drains
      opcode = OP_ADD; A = 32'd1; B = 32'd1; result = 32'd2;
      {carry, zero, negative, overflow} = 4'b0000;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk_cnt("halt_blocked");
      chk("halt_head", err_data, {4'd0, 32'h2, 32'h0, 4'b0000, 4'b0000});
      pop();
      chk("halt_drain", err_valid, 1'b1);

      // clear
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      e_pass = 0; e_fail = 0; e_skip = 0;
      chk_cnt("clear");
      chk("clear_halted", halted, 1'b0);
      chk("clear_errv", err_valid, 1'b0);
      chk("clear_ready", in_ready, 1'b1);

      // Reset with a transaction in stage 1
      send(OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000);
      rst_n = 1'b0;
      @(negedge clk);
      chk_cnt("midrst");
      chk("midrst_errv", err_valid, 1'b0);
      chk("midrst_ready", in_ready, 1'b0);
      rst_n = 1'b1;
      #1 chk("midrst_ready_rel", in_ready, 1'b0);
      @(negedge clk);
      chk("midrst_ready_edge", in_ready, 1'b1);
      @(negedge clk);
      chk_cnt("midrst_after");

      // Normal operation after reset
      send(OP_OR, 32'h00F0, 32'h000F, 32'h00FF, 4'b0000);
      @(negedge clk);
      e_pass = 1;
      chk_cnt("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
